// File: rtl/fifo_pop_arbiter.sv
// fifo_pop_arbiter: round-robin read-side controller for four source FIFOs.
// Pops at most one non-empty FIFO per cycle, applies a per-source burst
// limit and honours downstream pause. Each popped word is forwarded two
// edges after its read strobe, together with its source ID.
module fifo_pop_arbiter #(
    parameter int unsigned DATA_SIZE = 10,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           fifo_empty,
    input  logic [DATA_SIZE-1:0] data_in0,
    input  logic [DATA_SIZE-1:0] data_in1,
    input  logic [DATA_SIZE-1:0] data_in2,
    input  logic [DATA_SIZE-1:0] data_in3,
    input  logic                 downstream_pause,
    output logic [3:0]           read,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic [1:0]           src_id,
    output logic [15:0]          word_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    state_t               r_state;
    state_t               w_state_next;
    logic [1:0]           r_cur;
    logic [3:0]           r_burst_cnt;
    logic                 r_pend;
    logic [1:0]           r_pend_id;
    logic [DATA_SIZE-1:0] r_data_out;
    logic                 r_valid_out;
    logic [1:0]           r_src_id;
    logic [15:0]          r_word_count;

    logic                 w_cur_ok;
    logic                 w_found;
    logic [1:0]           w_grant;
    logic [1:0]           w_idx;
    logic                 w_pop;
    logic                 w_any_ready;
    logic [DATA_SIZE-1:0] w_sel_data;

    assign w_any_ready = ~&fifo_empty;

    // Grant selection: stay on the current source while its burst allows,
    // otherwise scan cur+1, cur+2, cur+3 and finally cur again.
    always_comb begin
        w_cur_ok = !fifo_empty[r_cur] && (r_burst_cnt < BURST_LIM);
        w_found  = 1'b0;
        w_grant  = r_cur;
        w_idx    = '0;
        if (w_cur_ok) begin
            w_found = 1'b1;
            w_grant = r_cur;
        end else begin
            for (int unsigned k = 1; k <= 4; k++) begin
                w_idx = r_cur + 2'(k);
                if (!w_found && !fifo_empty[w_idx]) begin
                    w_found = 1'b1;
                    w_grant = w_idx;
                end
            end
        end
    end

    // Read strobe: one-hot on the grant, blocked by pause and by reset.
    always_comb begin
        w_pop = w_found && !downstream_pause && reset;
        read  = w_pop ? (4'b0001 << w_grant) : '0;
    end

    // Next-state logic: pause dominates, then any non-empty source.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, ACTIVE, PAUSED: begin
                if (downstream_pause) begin
                    w_state_next = PAUSED;
                end else if (w_any_ready) begin
                    w_state_next = ACTIVE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, burst bookkeeping and pop tracking for the capture stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cur       <= '0;
            r_burst_cnt <= '0;
            r_pend      <= 1'b0;
            r_pend_id   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pop;
            if (w_pop) begin
                r_pend_id <= w_grant;
                // w_cur_ok implies the grant is cur; every other pop, including
                // the wrap-around re-grant of an over-limit cur, restarts the burst.
                if (w_cur_ok) begin
                    r_burst_cnt <= r_burst_cnt + 4'd1;
                end else begin
                    r_cur       <= w_grant;
                    r_burst_cnt <= 4'd1;
                end
            end
        end
    end

    // Select the word presented by the source popped on the previous edge.
    always_comb begin
        w_sel_data = data_in0;
        case (r_pend_id)
            2'd0: w_sel_data = data_in0;
            2'd1: w_sel_data = data_in1;
            2'd2: w_sel_data = data_in2;
            2'd3: w_sel_data = data_in3;
            default: w_sel_data = data_in0;
        endcase
    end

    // Capture stage: forward the pending word, count forwarded words.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_src_id     <= '0;
            r_word_count <= '0;
        end else if (r_pend) begin
            r_data_out   <= w_sel_data;
            r_src_id     <= r_pend_id;
            r_valid_out  <= 1'b1;
            r_word_count <= r_word_count + 16'd1;
        end else begin
            r_valid_out <= 1'b0;
        end
    end

    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign src_id     = r_src_id;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// tb_fifo_pop_arbiter: directed bench for fifo_pop_arbiter with behavioural
// source FIFOs. Word k of source i carries (i<<8)+k+1, truncated.
module tb_fifo_pop_arbiter;

    localparam int unsigned DW = 10;

    logic          clk;
    logic          reset;
    logic [3:0]    fifo_empty;
    logic [DW-1:0] din [4];
    logic          downstream_pause;
    logic [3:0]    read;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [1:0]    src_id;
    logic [15:0]   word_count;

    int unsigned wr_cnt [4];
    int unsigned rd_cnt [4];

    int n_tests = 0;
    int n_fail  = 0;
    int viol_cnt = 0;

    int            q_grant [$];
    int            q_vsrc  [$];
    logic [DW-1:0] q_vdata [$];

    fifo_pop_arbiter #(
        .DATA_SIZE (DW),
        .BURST_MAX (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fifo_empty       (fifo_empty),
        .data_in0         (din[0]),
        .data_in1         (din[1]),
        .data_in2         (din[2]),
        .data_in3         (din[3]),
        .downstream_pause (downstream_pause),
        .read             (read),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .src_id           (src_id),
        .word_count       (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] gen(input int unsigned i, input int unsigned k);
        return DW'((i << 8) + k + 1);
    endfunction

    // Source FIFO model: registered output word, empty flag updates on the pop edge.
    always_comb begin
        for (int i = 0; i < 4; i++) fifo_empty[i] = (wr_cnt[i] == rd_cnt[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (read[i]) begin
                din[i]    <= gen(i, rd_cnt[i]);
                rd_cnt[i] <= rd_cnt[i] + 1;
            end
        end
    end

    // Per-cycle monitor: read safety, grant log, forwarded-word log.
    always @(negedge clk) begin
        #2;
        if ((read & fifo_empty) != 4'b0) viol_cnt++;
        if (downstream_pause && read != 4'b0) viol_cnt++;
        if (!$onehot0(read)) viol_cnt++;
        else if (read != 4'b0) begin
            for (int i = 0; i < 4; i++) if (read[i]) q_grant.push_back(i);
        end
        if (valid_out) begin
            q_vsrc.push_back(int'(src_id));
            q_vdata.push_back(data_out);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int exp_rr [24] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0, 1,1, 2,2, 3,3};
    int exp_pz [12] = '{1,1, 1,1, 2,2,2,2, 1,1,1,1};

    initial begin
        int gs, vs;
        int kk [4];
        int unsigned base;
        bit reached;

        reset            = 1'b0;
        downstream_pause = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_cnt[i] = 1;
            rd_cnt[i] = 0;
            din[i]    = '0;
        end

        // Reset held with every source non-empty
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk($sformatf("rst_read_%0d", c), read, 4'b0);
            chk($sformatf("rst_valid_%0d", c), valid_out, 1'b0);
            chk($sformatf("rst_wc_%0d", c), word_count, 16'd0);
        end
        for (int i = 0; i < 4; i++) wr_cnt[i] = 0;
        @(negedge clk);
        reset = 1'b1;

        // Single source drain: FIFO0 holds 0x001..0x003
        @(negedge clk);
        gs = q_grant.size();
        vs = q_vsrc.size();
        wr_cnt[0] = wr_cnt[0] + 3;
        #1;
        chk("drain_read0", read, 4'b0001);
        repeat (8) @(negedge clk);
        #1;
        chk("drain_npops", q_grant.size() - gs, 3);
        chk("drain_nvalid", q_vsrc.size() - vs, 3);
        for (int j = 0; j < 3; j++) begin
            if (gs + j < q_grant.size()) chk($sformatf("drain_grant_%0d", j), q_grant[gs+j], 0);
            if (vs + j < q_vsrc.size()) begin
                chk($sformatf("drain_src_%0d", j), q_vsrc[vs+j], 0);
                chk($sformatf("drain_data_%0d", j), q_vdata[vs+j], 32'(j + 1));
            end
        end
        chk("drain_wc", word_count, 16'd3);
        chk("drain_read_idle", read, 4'b0);

        // Round-robin with burst limit 4, six words per source
        reset_dut();
        @(negedge clk);
        gs = q_grant.size();
        vs = q_vsrc.size();
        for (int i = 0; i < 4; i++) begin
            kk[i]     = int'(rd_cnt[i]);
            wr_cnt[i] = wr_cnt[i] + 6;
        end
        repeat (30) @(negedge clk);
        #1;
        chk("rr_npops", q_grant.size() - gs, 24);
        chk("rr_nvalid", q_vsrc.size() - vs, 24);
        for (int j = 0; j < 24; j++) begin
            if (gs + j < q_grant.size()) chk($sformatf("rr_grant_%0d", j), q_grant[gs+j], exp_rr[j]);
            if (vs + j < q_vsrc.size()) begin
                chk($sformatf("rr_src_%0d", j), q_vsrc[vs+j], exp_rr[j]);
                chk($sformatf("rr_data_%0d", j), q_vdata[vs+j], gen(exp_rr[j], kk[exp_rr[j]]));
            end
            kk[exp_rr[j]]++;
        end
        chk("rr_wc", word_count, 16'd24);

        // Pause mid-burst: FIFO1 8 words, FIFO2 4 words
        reset_dut();
        @(negedge clk);
        gs = q_grant.size();
        wr_cnt[1] = wr_cnt[1] + 8;
        wr_cnt[2] = wr_cnt[2] + 4;
        #1;
        chk("pz_read_c0", read, 4'b0010);
        @(negedge clk); #1;
        chk("pz_read_c1", read, 4'b0010);
        @(negedge clk);
        downstream_pause = 1'b1;
        #1;
        chk("pz_read_same_cycle", read, 4'b0);
        chk("pz_valid_n", valid_out, 1'b1);
        @(negedge clk); #1;
        chk("pz_read_n1", read, 4'b0);
        chk("pz_trailing_valid", valid_out, 1'b1);
        @(negedge clk); #1;
        chk("pz_valid_n2", valid_out, 1'b0);
        @(negedge clk); #1;
        chk("pz_valid_n3", valid_out, 1'b0);
        chk("pz_read_n3", read, 4'b0);
        @(negedge clk);
        downstream_pause = 1'b0;
        #1;
        chk("pz_resume_src", read, 4'b0010);
        repeat (16) @(negedge clk);
        #1;
        chk("pz_npops", q_grant.size() - gs, 12);
        for (int j = 0; j < 12; j++) begin
            if (gs + j < q_grant.size()) chk($sformatf("pz_grant_%0d", j), q_grant[gs+j], exp_pz[j]);
        end
        chk("pz_wc", word_count, 16'd12);
        chk("pz_last_src", src_id, 2'd1);

        // Reset dropped in the cycle after a pop
        @(negedge clk);
        wr_cnt[3] = wr_cnt[3] + 1;
        #1;
        chk("rf_read", read, 4'b1000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rf_read_in_reset", read, 4'b0);
        vs = q_vsrc.size();
        @(negedge clk); #1;
        chk("rf_valid", valid_out, 1'b0);
        chk("rf_data", data_out, '0);
        chk("rf_src", src_id, 2'd0);
        chk("rf_wc", word_count, 16'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rf_no_late_valid", q_vsrc.size() - vs, 0);

        // word_count wrap: stream 65537 words from FIFO2
        @(negedge clk);
        base = rd_cnt[2];
        wr_cnt[2] = wr_cnt[2] + 65537;
        reached = 1'b0;
        for (int c = 0; c < 70000 && !reached; c++) begin
            @(negedge clk); #1;
            if (valid_out && word_count == 16'hFFFE) reached = 1'b1;
        end
        chk("wrap_reach_fffe", 32'(reached), 32'd1);
        @(negedge clk); #1;
        chk("wrap_wc_ffff", word_count, 16'hFFFF);
        chk("wrap_valid_ffff", valid_out, 1'b1);
        @(negedge clk); #1;
        chk("wrap_wc_0000", word_count, 16'h0000);
        chk("wrap_valid_0000", valid_out, 1'b1);
        @(negedge clk); #1;
        chk("wrap_wc_0001", word_count, 16'h0001);
        chk("wrap_data_last", data_out, gen(2, base + 65536));
        chk("wrap_src_last", src_id, 2'd2);
        @(negedge clk); #1;
        chk("wrap_wc_hold", word_count, 16'h0001);
        chk("wrap_valid_end", valid_out, 1'b0);

        chk("no_bad_read", viol_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_pop_arbiter.md
# fifo_pop_arbiter

Read-side controller for the switch's per-channel FIFOs. It watches the empty flags of four source FIFOs and issues their `read` strobes, one FIFO per cycle, in round-robin order with a per-source burst limit. It captures each popped word and forwards it to the downstream stage with a valid strobe and a source ID. Downstream back-pressure (the next FIFO's `almost_full`/`fifo_pause`) is honoured through `downstream_pause`.

## Interface
- `DATA_SIZE`, default 10, width of data words; matches the source FIFOs.
- `BURST_MAX`, default 4, maximum consecutive pops from one source before the grant must rotate. Legal range is 1..15.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-low. Clock is `clk`.
- `fifo_empty` input, 4 bits: empty flag of source FIFO i (bit i).
- `data_in0`..`data_in3` input, DATA_SIZE bits each: popped-data outputs of source FIFOs 0..3.
- `downstream_pause` input, 1 bit: 1 means no new pops may be issued.
- `read` output, 4 bits: read strobes to the sources. Combinational, at most one bit high.
- `data_out` output, DATA_SIZE bits: forwarded word, registered.
- `valid_out` output, 1 bit: `data_out` is valid this cycle, registered.
- `src_id` output, 2 bits: index of the source that supplied `data_out`, registered.
- `word_count` output, 16 bits: total words forwarded since reset. Wraps at 0xFFFF to 0.

## Operation
- **State machine**, 2-bit state register with three states:
  - IDLE: all `fifo_empty` bits are 1.
  - ACTIVE: popping.
  - PAUSED: `downstream_pause` is 1.
- **State transitions**, evaluated every edge:
  - If `downstream_pause`=1, go to PAUSED, from any state.
  - Else if any `fifo_empty` bit is 0, go to ACTIVE.
  - Else go to IDLE.
- **Grant selection** is combinational from the registered state plus the current inputs.
  - Candidate order: `cur` first, if `cur` is not empty and `burst_cnt` < BURST_MAX.
  - Otherwise the first non-empty index, scanning `cur`+1, `cur`+2, `cur`+3, `cur` (modulo 4).
  - `read[g]`=1 only when `downstream_pause`=0, the reset input is 1, and source g is not empty.
- **`read` rules:**
  - `read` is never high for an empty FIFO.
  - `read` is never high while `downstream_pause` is high.
  - `read` is all-zero in IDLE.
- **Burst bookkeeping:**
  - On a pop from g = `cur`: `burst_cnt` <= `burst_cnt`+1.
  - On a pop from g ≠ `cur`: `cur` <= g, `burst_cnt` <= 1.
  - With no pop, both hold.
  - A source exceeding BURST_MAX while others are empty is re-granted: the scan wraps back to `cur`, and `burst_cnt` resets to 1.
- **Capture pipeline:**
  - A pop at edge N registers `pend`=1 and `pend_id`=g.
  - At edge N+1, if `pend`=1: `data_out` <= `data_in[pend_id]`, `src_id` <= `pend_id`, `valid_out` <= 1, `word_count` <= `word_count`+1.
  - Otherwise `valid_out` <= 0, and `data_out` and `src_id` hold.
- **Pause:** an in-flight capture (`pend`=1) always completes, so downstream must absorb one word after asserting pause.
- **Reset values:**
  - `read`=0, `data_out`=0, `valid_out`=0, `src_id`=0, `word_count`=0.
  - Internal: state=IDLE, `cur`=0, `burst_cnt`=0, `pend`=0.
- **Reset mid-operation:** a pending capture is discarded, and no `valid_out` follows it.

## Timing
- Pop-to-output latency is 2 edges. `read` is high in cycle N, `data_in` is valid in cycle N+1, and `valid_out`/`data_out` are high in cycle N+2.
- Throughput is 1 word per cycle. Back-to-back reads, same source or different sources, are allowed.
- `read` depends combinationally on `fifo_empty`, so a FIFO holding one word is popped once only: its empty flag rises the cycle after the pop.
- `downstream_pause` rising in cycle N blocks `read` in cycle N itself. At most one more `valid_out` follows, in cycle N+1.
- `word_count` counts `valid_out` cycles only. Arithmetic is modulo 2^16.

## Test plan
- **Reset:** hold reset=0 for 3 cycles with all FIFOs non-empty. Required: `read`=0, `valid_out`=0, `word_count`=0 throughout.
- **Single source drain:** FIFO0 loaded with 0x001..0x003, others empty. Required: `read`=0001 for 3 cycles, then `valid_out` for 3 cycles with `data_out` 0x001, 0x002, 0x003 and `src_id`=0, `word_count`=3, and no read to the empty FIFO.
- **Round-robin burst:** all four FIFOs hold 6 words each, BURST_MAX=4. Required grant sequence: 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,1,1,2,2,3,3. The last 8 are shortened because each FIFO empties. `word_count`=24.
- **Pause:** assert `downstream_pause` mid-burst. Required: `read`=0 from the same cycle, exactly one trailing `valid_out`, and the pop resumes at the same source with `burst_cnt` preserved after release.
- **Reset mid-flight:** drop reset in the cycle after a pop. Required: no `valid_out` for that word, and all outputs 0 on the next cycle.
- **Counter wrap:** preload/force `word_count`=0xFFFE, then forward 3 words. Required: `word_count` reads 0xFFFF, 0x0000, 0x0001.
